// File: rtl/sound_channel_if.sv
// Register-side bundle for one pulse-wave tone channel: tone controls in, PCM sample out.
interface sound_channel_if;
  logic        [15:0] period;
  logic        [4:0]  volume;
  logic        [2:0]  width;
  logic signed [23:0] sample;

  modport master (output period, output volume, output width, input sample);
  modport slave  (input period, input volume, input width, output sample);
endinterface

// File: rtl/sound_channel.sv
// Pulse-wave tone channel: an 8-step waveform with programmable step length, duty and
// amplitude, producing a registered signed 24-bit sample every clock.
module sound_channel (
  input  logic            clk,
  input  logic            rst_n,
  sound_channel_if.slave  bus
);

  logic        [15:0] div;
  logic        [2:0]  step;
  logic signed [23:0] sample_q;
  logic signed [23:0] magnitude;
  logic               high;
  logic signed [23:0] level;

  assign high      = (step <= bus.width);
  assign magnitude = {3'b000, bus.volume, 16'h0000};

  // NOTE: combinational blocks assign every output up front so no path leaves a latch.
  always_comb begin
    level = '0;
    if (bus.volume != 5'd0) begin
      level = high ? magnitude : -magnitude;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      step     <= '0;
      sample_q <= '0;
    end else begin
      sample_q <= level;
      // period 0 freezes the waveform; >= lets a lowered period wrap at once
      if (bus.period != 16'd0) begin
        if (div >= bus.period - 16'd1) begin
          div  <= '0;
          step <= step + 3'd1;
        end else begin
          div  <= div + 16'd1;
        end
      end
    end
  end

  assign bus.sample = sample_q;

endmodule

// File: tb/tb_sound_channel.sv
// Directed bench for sound_channel: hand-computed sample sequences covering reset,
// duty, volume, period freeze, period reduction and mid-waveform reset.
module tb_sound_channel;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sound_channel_if bus ();

  sound_channel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [23:0] POS1  = 24'h010000;
  localparam logic [23:0] NEG1  = 24'hFF0000;
  localparam logic [23:0] POS2  = 24'h020000;
  localparam logic [23:0] NEG2  = 24'hFE0000;
  localparam logic [23:0] POS5  = 24'h050000;
  localparam logic [23:0] NEG5  = 24'hFB0000;
  localparam logic [23:0] POS31 = 24'h1F0000;
  localparam logic [23:0] NEG31 = 24'hE10000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    end
  endtask

  // advance n rising edges, leaving time 1 unit past the last edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic [15:0] p, input logic [4:0] v, input logic [2:0] w);
    rst_n      = 1'b0;
    bus.period = p;
    bus.volume = v;
    bus.width  = w;
    tick(2);
    check("reset", bus.sample, 24'h000000);
    rst_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.period = '0;
    bus.volume = '0;
    bus.width  = '0;
    tick(1);

    // 1: silent channel; step keeps running underneath
    apply_reset(16'd4, 5'd0, 3'd3);
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      check("silent", bus.sample, 24'h000000);
    end
    bus.volume = 5'd1;
    bus.width  = 3'd0;
    tick(1);                               // edge 101, step 1
    check("silent_phase_step1", bus.sample, NEG1);
    tick(27);                              // edge 128, still step 7
    check("silent_phase_step7", bus.sample, NEG1);
    tick(1);                               // edge 129, step 0
    check("silent_phase_step0", bus.sample, POS1);

    // 2: 50% duty, period 2 -> 8 high, 8 low
    apply_reset(16'd2, 5'd1, 3'd3);
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      check("duty50", bus.sample, (((i - 1) % 16) < 8) ? POS1 : NEG1);
    end

    // 3: period 1, full volume, narrowest then widest duty
    apply_reset(16'd1, 5'd31, 3'd0);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      check("duty_min", bus.sample, (((i - 1) % 8) == 0) ? POS31 : NEG31);
    end
    bus.width = 3'd7;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("duty_max", bus.sample, POS31);
    end

    // 4: freeze with period 0, then resume from frozen div/step (step 2, div 1)
    apply_reset(16'd3, 5'd2, 3'd1);
    tick(6);
    check("pre_freeze_step1", bus.sample, POS2);
    tick(1);
    check("pre_freeze_step2", bus.sample, NEG2);
    bus.period = 16'd0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("frozen", bus.sample, NEG2);
    end
    bus.width = 3'd2;
    tick(1);
    check("frozen_width_update", bus.sample, POS2);
    bus.period = 16'd3;
    tick(1);
    check("resume_a", bus.sample, POS2);
    tick(1);
    check("resume_b", bus.sample, POS2);
    tick(1);
    check("resume_c", bus.sample, NEG2);

    // 5: period lowered below current div -> immediate wrap
    apply_reset(16'd1000, 5'd1, 3'd0);
    tick(800);
    check("long_step0", bus.sample, POS1);
    bus.period = 16'd10;
    tick(1);                               // edge 801: wraps, step -> 1
    check("shrink_edge801", bus.sample, POS1);
    tick(1);
    check("shrink_edge802", bus.sample, NEG1);
    tick(69);
    check("shrink_edge871", bus.sample, NEG1);
    tick(1);
    check("shrink_edge872", bus.sample, POS1);

    // 6: one-clock reset mid-high restarts at step 0, div 0
    apply_reset(16'd4, 5'd5, 3'd3);
    tick(3);
    check("mid_high", bus.sample, POS5);
    rst_n = 1'b0;
    tick(1);
    check("mid_reset", bus.sample, 24'h000000);
    rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      check("restart", bus.sample, (i <= 16) ? POS5 : NEG5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
